reg_writeback_stage: RTL and testbench

MEM/WB pipeline stage that sits directly upstream of the 16x16 register file and drives its single write port (destination register id, write enable, write data).
- Latches MEM-stage results and selects the writeback value (ALU result, load data or PC+2).
- Suppresses writes to R0.
- Tracks halt retirement and counts retired instructions.
- Optionally bypasses the in-flight write onto both register-file read ports.

---
 rtl/reg_writeback_stage.sv | 120 ++++++++++++
 tb/tb_reg_writeback_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_stage.sv
// reg_writeback_stage
//   MEM/WB pipeline register feeding the single write port of the 16x16
//   register file. It selects the writeback value (ALU result, load data or
//   PC+2), never writes R0, latches halt retirement and counts retired
//   instructions.
//
//   Build option: define WB_RF_BYPASS_EN to forward the in-flight write onto
//   both register-file read ports. When it is not defined the read ports pass
//   straight through and rf_src1_id/rf_src2_id are ignored.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   stall, flush    hold the stage / load a bubble (flush wins)
//   mem_*           MEM-stage instruction: valid, reg_write, dst_reg, wb_sel,
//                   alu_result, load_data, pc_plus2, halt
//   wb_dst_reg      register file DstReg
//   wb_write_reg    register file WriteReg
//   wb_dst_data     register file DstData
//   wb_valid        WB stage holds a real instruction
//   halted          sticky, set once a HLT has retired
//   retired_count   retired-instruction counter (wraps)
//   rf_srcN_id      read port register ids (bypass compare)
//   rf_srcN_raw     register file bitline data
//   rf_srcN_data    read port data delivered to decode
module reg_writeback_stage #(
  parameter int DATA_W   = 16,
  parameter int REG_ID_W = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic                mem_valid,
  input  logic                mem_reg_write,
  input  logic [REG_ID_W-1:0] mem_dst_reg,
  input  logic [1:0]          mem_wb_sel,
  input  logic [DATA_W-1:0]   mem_alu_result,
  input  logic [DATA_W-1:0]   mem_load_data,
  input  logic [DATA_W-1:0]   mem_pc_plus2,
  input  logic                mem_halt,
  output logic [REG_ID_W-1:0] wb_dst_reg,
  output logic                wb_write_reg,
  output logic [DATA_W-1:0]   wb_dst_data,
  output logic                wb_valid,
  output logic                halted,
  output logic [CNT_W-1:0]    retired_count,
  input  logic [REG_ID_W-1:0] rf_src1_id,
  input  logic [REG_ID_W-1:0] rf_src2_id,
  input  logic [DATA_W-1:0]   rf_src1_raw,
  input  logic [DATA_W-1:0]   rf_src2_raw,
  output logic [DATA_W-1:0]   rf_src1_data,
  output logic [DATA_W-1:0]   rf_src2_data
);

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_LOAD = 2'd1;
  localparam logic [1:0] SEL_PC2  = 2'd2;

  logic [DATA_W-1:0] sel_data;
  logic              write_en;

  // NOTE: every signal assigned in a combinational block gets a default first,
  // so no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_data = mem_alu_result;
    case (mem_wb_sel)
      SEL_LOAD: sel_data = mem_load_data;
      SEL_PC2:  sel_data = mem_pc_plus2;
      default:  sel_data = mem_alu_result;  // 0 and 3 both select the ALU
    endcase
  end

  // R0 is hard-wired zero in the register file, so a write is never issued;
  // a HLT retires without writing anything.
  assign write_en = mem_valid & mem_reg_write & (mem_dst_reg != '0) & ~mem_halt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid      <= 1'b0;
      wb_write_reg  <= 1'b0;
      wb_dst_reg    <= '0;
      wb_dst_data   <= '0;
      halted        <= 1'b0;
      retired_count <= '0;
    end else if (halted || flush) begin
      // Bubble: only the qualifiers are cleared; id/data are don't-care.
      wb_valid     <= 1'b0;
      wb_write_reg <= 1'b0;
    end else if (!stall) begin
      wb_valid     <= mem_valid;
      wb_dst_reg   <= mem_dst_reg;
      wb_dst_data  <= sel_data;
      wb_write_reg <= write_en;
      if (mem_valid) begin
        retired_count <= retired_count + CNT_W'(1);
      end
      if (mem_valid && mem_halt) begin
        halted <= 1'b1;
      end
    end
    // stall with no flush: every stage register holds, including write enable.
  end

`ifdef WB_RF_BYPASS_EN
  // Forward the value being written this cycle so decode never reads a stale
  // register. wb_write_reg is never set for R0, so R0 cannot bypass.
  assign rf_src1_data = (wb_write_reg && (rf_src1_id == wb_dst_reg)) ? wb_dst_data : rf_src1_raw;
  assign rf_src2_data = (wb_write_reg && (rf_src2_id == wb_dst_reg)) ? wb_dst_data : rf_src2_raw;
`else
  logic unused_src_ids;

  assign rf_src1_data   = rf_src1_raw;
  assign rf_src2_data   = rf_src2_raw;
  assign unused_src_ids = ^{rf_src1_id, rf_src2_id};
`endif

endmodule

// File: tb/tb_reg_writeback_stage.sv
// Self-checking bench for reg_writeback_stage: directed steps from the test
// plan followed by randomized traffic, all compared against a behavioural
// model of the stage kept in this file.
module tb_reg_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush;
  logic        mem_valid, mem_reg_write, mem_halt;
  logic [3:0]  mem_dst_reg;
  logic [1:0]  mem_wb_sel;
  logic [15:0] mem_alu_result, mem_load_data, mem_pc_plus2;
  logic [3:0]  wb_dst_reg;
  logic        wb_write_reg, wb_valid, halted;
  logic [15:0] wb_dst_data, retired_count;
  logic [3:0]  rf_src1_id, rf_src2_id;
  logic [15:0] rf_src1_raw, rf_src2_raw, rf_src1_data, rf_src2_data;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic        m_valid, m_write, m_halted, m_known;
  logic [3:0]  m_dst;
  logic [15:0] m_data, m_count;

  reg_writeback_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_dst_reg(mem_dst_reg), .mem_wb_sel(mem_wb_sel),
    .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
    .mem_pc_plus2(mem_pc_plus2), .mem_halt(mem_halt),
    .wb_dst_reg(wb_dst_reg), .wb_write_reg(wb_write_reg),
    .wb_dst_data(wb_dst_data), .wb_valid(wb_valid), .halted(halted),
    .retired_count(retired_count),
    .rf_src1_id(rf_src1_id), .rf_src2_id(rf_src2_id),
    .rf_src1_raw(rf_src1_raw), .rf_src2_raw(rf_src2_raw),
    .rf_src1_data(rf_src1_data), .rf_src2_data(rf_src2_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_write = 1'b0; m_halted = 1'b0; m_known = 1'b1;
    m_dst = 4'd0; m_data = 16'd0; m_count = 16'd0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    logic [15:0] choice [4];
    choice[0] = mem_alu_result;
    choice[1] = mem_load_data;
    choice[2] = mem_pc_plus2;
    choice[3] = mem_alu_result;
    if (m_halted || flush) begin
      m_valid = 1'b0; m_write = 1'b0; m_known = 1'b0;
    end else if (!stall) begin
      m_valid = mem_valid;
      m_dst   = mem_dst_reg;
      m_data  = choice[mem_wb_sel];
      m_write = mem_valid && mem_reg_write && (mem_dst_reg != 4'd0) && !mem_halt;
      m_known = 1'b1;
      if (mem_valid) m_count = m_count + 16'd1;
      if (mem_valid && mem_halt) m_halted = 1'b1;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".valid"},  32'(wb_valid),      32'(m_valid));
    check({tag, ".write"},  32'(wb_write_reg),  32'(m_write));
    check({tag, ".halted"}, 32'(halted),        32'(m_halted));
    check({tag, ".count"},  32'(retired_count), 32'(m_count));
    if (m_known) begin
      check({tag, ".dst"},  32'(wb_dst_reg),  32'(m_dst));
      check({tag, ".data"}, 32'(wb_dst_data), 32'(m_data));
    end
  endtask

  task automatic check_rf(input string tag);
    logic [15:0] e1, e2;
    e1 = rf_src1_raw;
    e2 = rf_src2_raw;
`ifdef WB_RF_BYPASS_EN
    if (m_write && rf_src1_id == m_dst) e1 = m_data;
    if (m_write && rf_src2_id == m_dst) e2 = m_data;
`endif
    #1;
    check({tag, ".src1"}, 32'(rf_src1_data), 32'(e1));
    check({tag, ".src2"}, 32'(rf_src2_data), 32'(e2));
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic set_mem(input logic v, input logic rw, input logic [3:0] dst,
                         input logic [1:0] sel, input logic [15:0] alu,
                         input logic [15:0] ld, input logic [15:0] pc, input logic h);
    mem_valid = v; mem_reg_write = rw; mem_dst_reg = dst; mem_wb_sel = sel;
    mem_alu_result = alu; mem_load_data = ld; mem_pc_plus2 = pc; mem_halt = h;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    check_state("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    set_mem(1'b0, 1'b0, 4'd0, 2'd0, 16'd0, 16'd0, 16'd0, 1'b0);
    rf_src1_id = 4'd0; rf_src2_id = 4'd0; rf_src1_raw = 16'd0; rf_src2_raw = 16'd0;
    model_reset();
    #2;
    do_reset();

    // Capture and select: load data, then PC+2
    set_mem(1'b1, 1'b1, 4'd5, 2'd1, 16'h1111, 16'hBEEF, 16'h2222, 1'b0);
    cycle("cap_load");
    check("cap_load.const_data", 32'(wb_dst_data), 32'h0000_BEEF);
    check("cap_load.const_count", 32'(retired_count), 32'd1);
    set_mem(1'b1, 1'b1, 4'd5, 2'd2, 16'h1111, 16'hBEEF, 16'h0042, 1'b0);
    cycle("cap_pc2");
    check("cap_pc2.const_data", 32'(wb_dst_data), 32'h0000_0042);
    set_mem(1'b1, 1'b1, 4'd9, 2'd3, 16'h7777, 16'hBEEF, 16'h0042, 1'b0);
    cycle("cap_sel3");

    // R0 suppression
    set_mem(1'b1, 1'b1, 4'd0, 2'd0, 16'h1234, 16'h0, 16'h0, 1'b0);
    cycle("r0");
    check("r0.const_write", 32'(wb_write_reg), 32'd0);

    // Stall with changing MEM inputs, then flush overriding stall
    set_mem(1'b1, 1'b1, 4'd3, 2'd0, 16'h3333, 16'h0, 16'h0, 1'b0);
    cycle("pre_stall");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_mem(1'b1, 1'b1, 4'(i + 10), 2'(i), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
      cycle("stall");
    end
    check("stall.const_dst", 32'(wb_dst_reg), 32'd3);
    flush = 1'b1;
    cycle("flush_stall");
    stall = 1'b0; flush = 1'b0;

    // Bypass: write R7=0xA5A5, read R7 and R6
    set_mem(1'b1, 1'b1, 4'd7, 2'd0, 16'hA5A5, 16'h0, 16'h0, 1'b0);
    cycle("byp_wr");
    rf_src1_id = 4'd7; rf_src1_raw = 16'h0000;
    rf_src2_id = 4'd6; rf_src2_raw = 16'h1111;
    check_rf("bypass");

    // Async reset between edges while a write is pending
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst.write", 32'(wb_write_reg), 32'd0);
    check("async_rst.valid", 32'(wb_valid), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Halt: HLT retires, then the stage is frozen
    set_mem(1'b1, 1'b1, 4'd2, 2'd0, 16'h0101, 16'h0, 16'h0, 1'b0);
    cycle("pre_halt");
    set_mem(1'b1, 1'b1, 4'd4, 2'd0, 16'h0202, 16'h0, 16'h0, 1'b1);
    cycle("halt");
    check("halt.const_halted", 32'(halted), 32'd1);
    check("halt.const_count", 32'(retired_count), 32'd2);
    for (int i = 0; i < 3; i++) begin
      set_mem(1'b1, 1'b1, 4'(i + 1), 2'd0, 16'($urandom), 16'h0, 16'h0, 1'b0);
      cycle("halted_frozen");
    end
    do_reset();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 9) == 0);
      set_mem($urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0, 4'($urandom),
              2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
              $urandom_range(0, 69) == 0);
      cycle("rand");
      rf_src1_id  = ($urandom_range(0, 1) == 0) ? m_dst : 4'($urandom);
      rf_src2_id  = ($urandom_range(0, 1) == 0) ? m_dst : 4'($urandom);
      rf_src1_raw = 16'($urandom);
      rf_src2_raw = 16'($urandom);
      check_rf("rand_rf");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
